// File: rtl/k12a_input_sync_if.sv
// k12a_input_sync_if: board-input conditioning bundle.
// master drives raw inputs and wake control; slave returns conditioned levels.
interface k12a_input_sync_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] wake_mask;
  logic             wake_ack;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] wake_pending;
  logic             wake;

  modport master (
    output raw_in,
    output wake_mask,
    output wake_ack,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse,
    input  wake_pending,
    input  wake
  );

  modport slave (
    input  raw_in,
    input  wake_mask,
    input  wake_ack,
    output clean_out,
    output rise_pulse,
    output fall_pulse,
    output wake_pending,
    output wake
  );
endinterface

// File: rtl/k12a_input_sync.sv
// k12a_input_sync: synchroniser, debouncer, edge pulses and sticky wake.
// Define K12A_INPUT_SYNC_FALL_WAKE_EN to let masked 1->0 edges wake too.
module k12a_input_sync #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               cpu_clock,
  input  logic               reset_n,
  k12a_input_sync_if.slave   io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] wake_ev;

  always_comb begin
    sync_d[0] = io.raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        clean_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise_d = clean_d & ~clean_q;
  assign fall_d = ~clean_d & clean_q;

`ifdef K12A_INPUT_SYNC_FALL_WAKE_EN
  assign wake_ev = (rise_d | fall_d) & io.wake_mask;
`else
  assign wake_ev = rise_d & io.wake_mask;
`endif

  // A new event on the ack edge survives the clear.
  always_comb begin
    pend_d = io.wake_ack ? '0 : pend_q;
    pend_d = pend_d | wake_ev;
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign io.clean_out    = clean_q;
  assign io.rise_pulse   = rise_q;
  assign io.fall_pulse   = fall_q;
  assign io.wake_pending = pend_q;
  assign io.wake         = |pend_q;

endmodule

// File: tb/tb_k12a_input_sync.sv
// tb_k12a_input_sync: directed scenarios plus randomized run
// against a sliding-window reference model.
module tb_k12a_input_sync;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;
  localparam int LAT = S + D;

`ifdef K12A_INPUT_SYNC_FALL_WAKE_EN
  localparam logic FALL_WAKE = 1'b1;
`else
  localparam logic FALL_WAKE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  k12a_input_sync_if #(.WIDTH(W)) bus ();

  k12a_input_sync #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .cpu_clock(clk),
    .reset_n(rst_n),
    .io(bus)
  );

  // Reference: hist[j] is raw_in sampled j+1 edges ago. The core logic
  // sees raw from S edges back; clean flips once the last D seen
  // samples all disagree with it.
  logic [W-1:0] hist [0:S+D-2];
  logic [W-1:0] m_clean, m_rise, m_fall, m_pend, nc, ev;

  always_comb begin
    nc = m_clean;
    for (int i = 0; i < W; i++) begin
      logic stable;
      stable = 1'b1;
      for (int j = S - 1; j <= S + D - 2; j++) begin
        if (hist[j][i] == m_clean[i]) stable = 1'b0;
      end
      if (stable) nc[i] = ~m_clean[i];
    end
    ev = (nc & ~m_clean) & bus.wake_mask;
    if (FALL_WAKE) ev = ev | ((~nc & m_clean) & bus.wake_mask);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S + D - 2; k++) hist[k] <= '0;
      m_clean <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_pend  <= '0;
    end else begin
      hist[0] <= bus.raw_in;
      for (int k = 1; k <= S + D - 2; k++) hist[k] <= hist[k-1];
      m_clean <= nc;
      m_rise  <= nc & ~m_clean;
      m_fall  <= ~nc & m_clean;
      m_pend  <= (bus.wake_ack ? '0 : m_pend) | ev;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.wake_ack = 1'b1;
    step();
    bus.wake_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_c, exp_r;
    rst_n = 1'b0;
    bus.raw_in = 8'hFF;
    bus.wake_mask = '0;
    bus.wake_ack = 1'b0;
    repeat (5) step();
    checks++;
    if ({bus.clean_out, bus.rise_pulse, bus.fall_pulse,
         bus.wake_pending, bus.wake} !== '0) begin
      errors++;
      $display("FAIL reset_outs got c=%h r=%h f=%h p=%h w=%b want 0",
               bus.clean_out, bus.rise_pulse, bus.fall_pulse,
               bus.wake_pending, bus.wake);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= LAT + 3; n++) begin
      step();
      exp_c = (n >= LAT) ? 8'hFF : 8'h00;
      exp_r = (n == LAT) ? 8'hFF : 8'h00;
      checks++;
      if (bus.clean_out !== exp_c || bus.rise_pulse !== exp_r) begin
        errors++;
        $display("FAIL reset_release edge %0d got c=%h r=%h want c=%h r=%h",
                 n, bus.clean_out, bus.rise_pulse, exp_c, exp_r);
      end
    end
  endtask

  task automatic test_latency();
    logic ec, er;
    bus.raw_in = 8'h00;
    repeat (10) step();
    bus.raw_in[0] = 1'b1;
    for (int n = 1; n <= LAT + 3; n++) begin
      step();
      ec = (n >= LAT);
      er = (n == LAT);
      checks++;
      if (bus.clean_out[0] !== ec || bus.rise_pulse[0] !== er) begin
        errors++;
        $display("FAIL latency edge %0d got c=%b r=%b want c=%b r=%b",
                 n, bus.clean_out[0], bus.rise_pulse[0], ec, er);
      end
    end
  endtask

  task automatic test_glitch();
    bus.raw_in[3] = 1'b1;
    repeat (D - 1) step();
    bus.raw_in[3] = 1'b0;
    for (int n = 0; n < LAT + 4; n++) begin
      step();
      checks++;
      if (bus.clean_out[3] !== 1'b0 || bus.rise_pulse[3] !== 1'b0 ||
          bus.fall_pulse[3] !== 1'b0 || bus.wake !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d got c=%b r=%b f=%b w=%b want 0",
                 n, bus.clean_out[3], bus.rise_pulse[3],
                 bus.fall_pulse[3], bus.wake);
      end
    end
  endtask

  task automatic test_wake_mask();
    bus.wake_mask = 8'h04;
    bus.raw_in = bus.raw_in | 8'h24;
    repeat (LAT + 2) step();
    checks++;
    if (bus.wake_pending !== 8'h04 || bus.wake !== 1'b1) begin
      errors++;
      $display("FAIL wake_mask got p=%h w=%b want p=04 w=1",
               bus.wake_pending, bus.wake);
    end
    pulse_ack();
    checks++;
    if (bus.wake_pending !== 8'h00 || bus.wake !== 1'b0) begin
      errors++;
      $display("FAIL wake_ack got p=%h w=%b want p=00 w=0",
               bus.wake_pending, bus.wake);
    end
  endtask

  task automatic test_collision();
    bus.raw_in = bus.raw_in & ~8'h24;
    repeat (LAT + 2) step();
    pulse_ack();
    bus.wake_mask = 8'h44;
    bus.raw_in[6] = 1'b1;
    repeat (LAT + 2) step();
    checks++;
    if (bus.wake_pending !== 8'h40) begin
      errors++;
      $display("FAIL collision_pre got p=%h want 40", bus.wake_pending);
    end
    bus.raw_in[2] = 1'b1;
    repeat (LAT - 1) step();
    bus.wake_ack = 1'b1;
    step();
    bus.wake_ack = 1'b0;
    checks++;
    if (bus.wake_pending !== 8'h04 || bus.rise_pulse[2] !== 1'b1) begin
      errors++;
      $display("FAIL collision got p=%h r2=%b want p=04 r2=1",
               bus.wake_pending, bus.rise_pulse[2]);
    end
  endtask

  task automatic test_fall_wake();
    int highs;
    logic [W-1:0] exp_p;
    pulse_ack();
    bus.wake_mask = 8'h01;
    bus.raw_in[0] = 1'b0;
    highs = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      step();
      if (bus.fall_pulse[0] === 1'b1) highs++;
    end
    checks++;
    if (highs != 1 || bus.clean_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse got highs=%0d c0=%b want highs=1 c0=0",
               highs, bus.clean_out[0]);
    end
    exp_p = FALL_WAKE ? 8'h01 : 8'h00;
    checks++;
    if (bus.wake_pending !== exp_p) begin
      errors++;
      $display("FAIL fall_wake got p=%h want %h", bus.wake_pending, exp_p);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] t;
    for (int c = 0; c < 1500; c++) begin
      t = '0;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(5) == 0) t[i] = 1'b1;
      end
      bus.raw_in = bus.raw_in ^ t;
      if (c % 50 == 0) bus.wake_mask = W'($urandom);
      bus.wake_ack = ($urandom_range(9) == 0);
      if (c == 700) rst_n = 1'b0;
      if (c == 703) rst_n = 1'b1;
      step();
      checks++;
      if (bus.clean_out !== m_clean) begin
        errors++;
        $display("FAIL rnd_clean cyc %0d got %h want %h",
                 c, bus.clean_out, m_clean);
      end
      checks++;
      if (bus.rise_pulse !== m_rise || bus.fall_pulse !== m_fall) begin
        errors++;
        $display("FAIL rnd_pulse cyc %0d got r=%h f=%h want r=%h f=%h",
                 c, bus.rise_pulse, bus.fall_pulse, m_rise, m_fall);
      end
      checks++;
      if (bus.wake_pending !== m_pend || bus.wake !== (|m_pend)) begin
        errors++;
        $display("FAIL rnd_wake cyc %0d got p=%h w=%b want p=%h w=%b",
                 c, bus.wake_pending, bus.wake, m_pend, |m_pend);
      end
      checks++;
      if ((bus.rise_pulse & bus.fall_pulse) !== '0) begin
        errors++;
        $display("FAIL rnd_both cyc %0d got r&f=%h want 00",
                 c, bus.rise_pulse & bus.fall_pulse);
      end
    end
    bus.wake_ack = 1'b0;
  endtask

  initial begin
    bus.raw_in = 8'hFF;
    bus.wake_mask = '0;
    bus.wake_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_wake_mask();
    test_collision();
    test_fall_wake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k12a_input_sync.md
Name: k12a_input_sync

Overview:
- Input-conditioning stage directly upstream of the k12a core.
- Takes asynchronous board-level inputs (buttons, switches, external event lines) and produces synchronised, debounced levels that feed the core's gpio_in*/wake_sources pins.
- Also produces one-cycle edge pulses and a sticky, maskable wake request.
- Runs on cpu_clock.

Parameters:
- WIDTH, 8: number of input lines conditioned.
- SYNC_STAGES, 2: flip-flop synchroniser depth per bit; must be >= 2.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required before clean level changes; must be >= 1; counter width = $clog2(DEBOUNCE_CYCLES)+1.

Ports:
- cpu_clock  input  1  core clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- raw_in  input  WIDTH  asynchronous board inputs.
- wake_mask  input  WIDTH  per-bit enable for wake capture (synchronous to cpu_clock).
- wake_ack  input  1  synchronous clear-all of pending wake bits.
- clean_out  output  WIDTH  debounced level; drives core gpio_in/wake_sources.
- rise_pulse  output  WIDTH  one-cycle pulse on clean 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse on clean 1->0.
- wake_pending  output  WIDTH  sticky captured wake events.
- wake  output  1  OR-reduction of wake_pending.

Behaviour:
- Reset, asynchronous while reset_n low:
  - Clears all synchroniser flops, counters, clean_out, rise_pulse, fall_pulse and wake_pending to 0.
  - wake is therefore 0.
  - Reset mid-debounce discards the partial count.
- Synchroniser:
  - raw_in[i] passes through SYNC_STAGES flops.
  - s[i] is the last stage.
  - No logic between stages.
- Debounce, independently per bit, at each rising edge:
  - s==clean: cnt<=0.
  - s!=clean and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s!=clean and cnt==DEBOUNCE_CYCLES-1: clean<=s, cnt<=0.
- Latency:
  - Count the first edge that samples a new stable raw value as edge 1.
  - clean_out changes after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults: 18 edges.
  - DEBOUNCE_CYCLES=1: clean updates one edge after s changes.
- Glitch rejection: any s excursion lasting fewer than DEBOUNCE_CYCLES cycles leaves clean unchanged and resets the count.
- Edge pulses:
  - rise_pulse/fall_pulse are registered, set on the same edge clean changes, and cleared on the next edge.
  - Each pulse is exactly one cycle high, coincident with the first cycle of the new clean level.
  - A bit never shows rise and fall together.
- Wake capture, on the edge where clean[i] goes 0->1 with wake_mask[i]=1: wake_pending[i]<=1.
- Wake clearing:
  - wake_ack=1 clears all pending bits on the next edge.
  - A set event on the same edge as wake_ack wins: that bit stays 1, other bits clear.
  - Deasserting wake_mask[i] does not clear an already-pending bit.
- Timing: wake is combinational from wake_pending registers only, so there is no combinational path from raw_in.

Optional Feature:
- Macro: K12A_INPUT_SYNC_FALL_WAKE_EN.
- Defined: a clean 1->0 transition on a masked bit also sets wake_pending[i], with the same ack/priority rules.
- Undefined: only 0->1 transitions set wake_pending; fall_pulse still operates normally.

Test Plan:
- Reset: hold reset_n=0 with raw_in=8'hFF for 5 cycles -> all outputs 0. Release -> clean_out=8'hFF after 18 edges; rise_pulse=8'hFF for exactly one cycle.
- Debounce latency (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): raw_in[0] steps 0->1 and holds -> clean_out[0] rises after edge 6; rise_pulse[0] high only during cycle 6.
- Glitch rejection (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): raw_in[3] high for 3 cycles, then low -> clean_out[3] stays 0; no pulses; wake stays 0.
- Wake mask and ack:
  - wake_mask=8'h04; raise raw_in[2] and raw_in[5] -> wake_pending=8'h04, wake=1.
  - Pulse wake_ack -> wake_pending=8'h00 next edge.
- Ack/set collision: assert wake_ack on the same edge clean_out[2] rises with mask bit set, while wake_pending[6] is already 1 -> wake_pending=8'h04.
- Falling wake: wake_mask=8'h01; drop clean_out[0] 1->0 -> fall_pulse[0] one cycle. With K12A_INPUT_SYNC_FALL_WAKE_EN defined, wake_pending=8'h01; without it, wake_pending=8'h00.
